reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two, 2..64; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, read-port count, 1..4.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset: asynchronous assert, active-low, synchronous deassert by the environment.
REQ-006 SHALL have port raddr  input  NRD x AW  read addresses, one per port.
REQ-007 SHALL have port rdata  output  NRD x XLEN  read data, one per port.
REQ-008 SHALL have port rbusy  output  NRD  per-port hazard flag: source register has an outstanding producer.
REQ-009 SHALL have port iss_en  input  1  issue strobe: mark iss_rd busy.
REQ-010 SHALL have port iss_rd  input  AW  destination register of the issuing instruction.
REQ-011 SHALL have port wb_en  input  1  writeback strobe: write wb_data, clear busy.
REQ-012 SHALL have port wb_rd  input  AW  writeback destination.
REQ-013 SHALL have port wb_data  input  XLEN  writeback data.
REQ-014 SHALL have port busy_cnt  output  AW+1  number of registers currently busy.

Function
REQ-015 SHALL write wb_data into wb_rd on the rising edge when wb_en=1 and wb_rd!=0.
REQ-016 SHALL hold register 0 at zero permanently; writes, issues and writebacks to 0 are ignored.
REQ-017 SHALL read combinationally: rdata[i] = reg[raddr[i]], zero latency.
REQ-018 SHALL bypass: when wb_en=1, wb_rd!=0 and wb_rd==raddr[i], rdata[i] = wb_data in that same cycle.
REQ-019 SHALL set busy[iss_rd] on the rising edge when iss_en=1 and iss_rd!=0.
REQ-020 SHALL clear busy[wb_rd] on the rising edge when wb_en=1, unless REQ-021 applies.
REQ-021 SHALL give issue priority when iss_en and wb_en target the same non-zero register in one cycle: data is written and busy stays or becomes 1.
REQ-022 SHALL drive rbusy[i] = busy[raddr[i]] AND NOT (wb_en AND wb_rd==raddr[i]) for raddr[i]!=0; rbusy[i]=0 for raddr[i]==0.
REQ-023 SHALL leave busy unchanged for a wb_en to a non-busy register; the data is still written.
REQ-024 SHALL leave busy at 1 for iss_en to an already-busy register; busy_cnt is unchanged.
REQ-025 SHALL update busy_cnt registered, equal to the popcount of busy after each edge.
REQ-026 SHALL keep busy_cnt <= NREGS-1 and never wrap.
REQ-027 SHALL make all read ports independent; identical addresses on several ports return identical data and flags.

Reset
REQ-028 SHALL clear all registers, all busy bits and busy_cnt to 0 immediately on rst=0, regardless of clk.
REQ-029 SHALL drive rdata=0, rbusy=0 and busy_cnt=0 while rst=0.
REQ-030 SHALL discard iss_en and wb_en while rst=0; reset mid-operation loses outstanding producers without error.

Structure
REQ-031 SHALL place XLEN/NREGS defaults and the AW derivation in shared package rf_pkg.
REQ-032 SHALL implement busy bits, the priority rule and busy_cnt in sub-module rf_scoreboard; the storage array and bypass stay in the top.
REQ-033 SHALL use no negedge logic; all state uses one rising-edge process domain.

Verification
REQ-034 SHALL check write then read: wb x5=0xDEADBEEF, next cycle raddr[0]=5 -> rdata[0]=0xDEADBEEF.
REQ-035 SHALL check bypass: wb x7=0x12345678 with raddr[1]=7 in the same cycle -> rdata[1]=0x12345678 and rbusy[1]=0.
REQ-036 SHALL check x0: wb x0=0xFFFFFFFF and iss_rd=0 -> rdata=0, rbusy=0, busy_cnt=0.
REQ-037 SHALL check the scoreboard: issue x3, then x4 -> busy_cnt=2; wb x3 -> busy_cnt=1, rbusy for x3=0.
REQ-038 SHALL check the collision: x9 busy, iss_en and wb_en both on x9 with data 0xA5 -> reg x9=0xA5, busy stays 1, busy_cnt unchanged.
REQ-039 SHALL check async reset: x2=0x55 with 3 registers busy, assert rst=0 between edges -> rdata, rbusy and busy_cnt are 0 at once.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and derived widths for the scoreboarded register file.
package rf_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned NRD_DEFAULT   = 2;

  // Address width for a power-of-two register count.
  function automatic int unsigned addr_width(input int unsigned nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Read ports, issue/writeback strobes and scoreboard count for reg_file_sb.
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned NRD   = NRD_DEFAULT
);

  localparam int unsigned AW = addr_width(NREGS);

  logic [NRD-1:0][AW-1:0]   raddr;
  logic [NRD-1:0][XLEN-1:0] rdata;
  logic [NRD-1:0]           rbusy;
  logic                     iss_en;
  logic [AW-1:0]            iss_rd;
  logic                     wb_en;
  logic [AW-1:0]            wb_rd;
  logic [XLEN-1:0]          wb_data;
  logic [AW:0]              busy_cnt;

  modport master (
    output raddr, iss_en, iss_rd, wb_en, wb_rd, wb_data,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  raddr, iss_en, iss_rd, wb_en, wb_rd, wb_data,
    output rdata, rbusy, busy_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with issue-over-writeback priority, hazard lookup and
// a registered popcount of outstanding producers.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned NRD   = NRD_DEFAULT,
  localparam int unsigned AW   = addr_width(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_en_i,
  input  logic [AW-1:0]          iss_rd_i,
  input  logic                   wb_en_i,
  input  logic [AW-1:0]          wb_rd_i,
  input  logic [NRD-1:0][AW-1:0] raddr_i,
  output logic [NRD-1:0]         rbusy_o,
  output logic [AW:0]            busy_cnt_o
);

  localparam int unsigned CntW = AW + 1;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    if (wb_en_i && (wb_rd_i != '0)) begin
      busy_d[wb_rd_i] = 1'b0;
    end
    // Applied last so a same-cycle issue to the written register keeps it busy.
    if (iss_en_i && (iss_rd_i != '0)) begin
      busy_d[iss_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + CntW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // A writeback landing this cycle resolves the hazard for its readers.
  always_comb begin
    rbusy_o = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (raddr_i[i] != '0) begin
        rbusy_o[i] = busy_q[raddr_i[i]] && !(wb_en_i && (wb_rd_i == raddr_i[i]));
      end
    end
  end

  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with writeback bypass and an attached scoreboard.
// Register 0 reads as zero and ignores writes, issues and writebacks.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = NREGS_DEFAULT,
  parameter int unsigned NRD   = NRD_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);

  localparam int unsigned AW = addr_width(NREGS);

  logic [XLEN-1:0]          regs_q [NREGS];
  logic [XLEN-1:0]          regs_d [NREGS];
  logic                     wb_wr;
  logic [NRD-1:0][XLEN-1:0] rdata;

  assign wb_wr = bus.wb_en && (bus.wb_rd != '0);

  always_comb begin
    regs_d = regs_q;
    if (wb_wr) begin
      regs_d[bus.wb_rd] = bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads are gated by reset so a bypassed writeback cannot leak out.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (rst) begin
        if (wb_wr && (bus.wb_rd == bus.raddr[i])) begin
          rdata[i] = bus.wb_data;
        end else begin
          rdata[i] = regs_q[bus.raddr[i]];
        end
      end
    end
  end

  assign bus.rdata = rdata;

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .iss_en_i   (bus.iss_en),
    .iss_rd_i   (bus.iss_rd),
    .wb_en_i    (bus.wb_en),
    .wb_rd_i    (bus.wb_rd),
    .raddr_i    (bus.raddr),
    .rbusy_o    (bus.rbusy),
    .busy_cnt_o (bus.busy_cnt)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vector table plus hand-written reset and saturation sequences.
module tb_reg_file_sb;

  logic clk;
  logic rst;

  reg_file_sb_if bus ();

  reg_file_sb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
    logic [1:0]  exp_rbusy;
    logic [5:0]  exp_cnt;
  } vec_t;

  int n_checks;
  int n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ie, input logic [4:0] ir, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] a0, input logic [4:0] a1);
    bus.iss_en   = ie;
    bus.iss_rd   = ir;
    bus.wb_en    = we;
    bus.wb_rd    = wr;
    bus.wb_data  = wd;
    bus.raddr[0] = a0;
    bus.raddr[1] = a1;
  endtask

  vec_t vecs [17];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    //           ie    ird    we    wrd    wdata         ra0    ra1    exp0          exp1          rbusy  cnt
    vecs[0]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
    vecs[1]  = '{1'b0, 5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 6'd0};
    vecs[2]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 6'd0};
    vecs[3]  = '{1'b0, 5'd0,  1'b1, 5'd7,  32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'h12345678, 2'b00, 6'd0};
    vecs[4]  = '{1'b1, 5'd0,  1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
    vecs[5]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h12345678, 2'b00, 6'd0};
    vecs[6]  = '{1'b1, 5'd3,  1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  32'h0,        32'h0,        2'b00, 6'd0};
    vecs[7]  = '{1'b1, 5'd4,  1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  32'h0,        32'h0,        2'b01, 6'd1};
    vecs[8]  = '{1'b0, 5'd0,  1'b1, 5'd3,  32'h33,       5'd3,  5'd4,  32'h33,       32'h0,        2'b10, 6'd2};
    vecs[9]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  32'h33,       32'h0,        2'b10, 6'd1};
    vecs[10] = '{1'b1, 5'd9,  1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  32'h0,        32'h0,        2'b00, 6'd1};
    vecs[11] = '{1'b1, 5'd9,  1'b1, 5'd9,  32'hA5,       5'd9,  5'd9,  32'hA5,       32'hA5,       2'b00, 6'd2};
    vecs[12] = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  32'hA5,       32'hA5,       2'b11, 6'd2};
    vecs[13] = '{1'b1, 5'd4,  1'b0, 5'd0,  32'h0,        5'd4,  5'd9,  32'h0,        32'hA5,       2'b11, 6'd2};
    vecs[14] = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd4,  5'd9,  32'h0,        32'hA5,       2'b11, 6'd2};
    vecs[15] = '{1'b0, 5'd0,  1'b1, 5'd5,  32'h77,       5'd5,  5'd4,  32'h77,       32'h0,        2'b10, 6'd2};
    vecs[16] = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        5'd5,  5'd4,  32'h77,       32'h0,        2'b10, 6'd2};

    // Reset state, with strobes active to show they are ignored.
    @(negedge clk);
    drive(1'b1, 5'd6, 1'b1, 5'd6, 32'h1111, 5'd6, 5'd6);
    #2;
    check("rst_rdata0", bus.rdata[0], 32'h0);
    check("rst_rbusy", {30'd0, bus.rbusy}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_cnt", {26'd0, bus.busy_cnt}, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].iss_en, vecs[i].iss_rd, vecs[i].wb_en, vecs[i].wb_rd, vecs[i].wb_data,
            vecs[i].ra0, vecs[i].ra1);
      #2;
      check($sformatf("v%0d_rdata0", i), bus.rdata[0], vecs[i].exp_rd0);
      check($sformatf("v%0d_rdata1", i), bus.rdata[1], vecs[i].exp_rd1);
      check($sformatf("v%0d_rbusy", i), {30'd0, bus.rbusy}, {30'd0, vecs[i].exp_rbusy});
      check($sformatf("v%0d_cnt", i), {26'd0, bus.busy_cnt}, {26'd0, vecs[i].exp_cnt});
    end

    // Async reset mid-operation: x2 = 0x55, busy = {x4, x9, x10}.
    @(negedge clk);
    drive(1'b1, 5'd10, 1'b1, 5'd2, 32'h55, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd4);
    #2;
    check("pre_rst_rdata0", bus.rdata[0], 32'h55);
    check("pre_rst_rbusy", {30'd0, bus.rbusy}, 32'h2);
    check("pre_rst_cnt", {26'd0, bus.busy_cnt}, 32'd3);
    #1;
    rst = 1'b0;
    #1;
    check("async_rdata0", bus.rdata[0], 32'h0);
    check("async_rbusy", {30'd0, bus.rbusy}, 32'h0);
    check("async_cnt", {26'd0, bus.busy_cnt}, 32'h0);
    drive(1'b1, 5'd2, 1'b1, 5'd2, 32'hFF, 5'd2, 5'd2);
    #1;
    check("rst_bypass_gated", bus.rdata[0], 32'h0);
    @(posedge clk);
    #1;
    check("rst_edge_rdata1", bus.rdata[1], 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd2);
    rst = 1'b1;
    #2;
    check("post_rst_rdata0", bus.rdata[0], 32'h0);
    check("post_rst_cnt", {26'd0, bus.busy_cnt}, 32'h0);

    // Saturation: every non-zero register busy, then a redundant issue.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      drive(1'b1, 5'(r), 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    end
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd0);
    #2;
    check("sat_cnt", {26'd0, bus.busy_cnt}, 32'd31);
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd0);
    #2;
    check("sat_cnt_hold", {26'd0, bus.busy_cnt}, 32'd31);
    check("sat_rbusy", {30'd0, bus.rbusy}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
